// File: rtl/fir_pkg.sv
// Shared FIR constants and coefficient-loader state encodings.
package fir_pkg;

  localparam int unsigned FIR_NUM_TAPS = 74;
  localparam int unsigned FIR_COEF_W   = 8;
  localparam int unsigned FIR_ADDR_W   = 7;

  typedef enum logic [1:0] {
    LDR_IDLE   = 2'd0,
    LDR_LOAD   = 2'd1,
    LDR_DRAIN  = 2'd2,
    LDR_COMMIT = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// Two-bank coefficient register file: one write port, one registered read port.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS = FIR_NUM_TAPS,
  parameter int unsigned COEF_W   = FIR_COEF_W,
  parameter int unsigned ADDR_W   = FIR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              we,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COEF_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] TAP_END = ADDR_W'(NUM_TAPS);

  logic [COEF_W-1:0] mem_q [2][NUM_TAPS];
  logic [COEF_W-1:0] mem_d [2][NUM_TAPS];
  logic [COEF_W-1:0] rd_data_q, rd_data_d;

  // Out-of-range addresses never write and always read back as zero.
  always_comb begin
    mem_d = mem_q;
    if (we && (wr_addr < TAP_END)) begin
      mem_d[wr_bank][wr_addr] = wr_data;
    end
    rd_data_d = '0;
    if (rd_addr < TAP_END) begin
      rd_data_d = mem_q[rd_bank][rd_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '{default: '0};
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_coef_loader.sv
// Coefficient stream loader: fills the shadow bank, swaps it active on a
// correctly framed set, flags malformed frames.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS = FIR_NUM_TAPS,
  parameter int unsigned COEF_W   = FIR_COEF_W,
  parameter int unsigned ADDR_W   = FIR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [COEF_W-1:0] s_data,
  input  logic              s_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COEF_W-1:0] rd_coef,
  output logic              bank_sel,
  output logic              coef_valid,
  output logic              commit,
  output logic              len_err
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_TAPS - 1);

  ldr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              s_ready_q, s_ready_d;
  logic              bank_sel_q, bank_sel_d;
  logic              coef_valid_q, coef_valid_d;
  logic              commit_q, commit_d;
  logic              len_err_q, len_err_d;

  logic              beat_c;
  logic              we_c;
  logic [ADDR_W-1:0] wr_addr_c;

  assign beat_c = s_valid && s_ready_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    bank_sel_d   = bank_sel_q;
    coef_valid_d = coef_valid_q;
    commit_d     = 1'b0;
    len_err_d    = 1'b0;
    we_c         = 1'b0;
    wr_addr_c    = wr_ptr_q;

    unique case (state_q)
      LDR_IDLE: begin
        wr_addr_c = '0;
        if (beat_c) begin
          we_c = 1'b1;
          if (s_last) begin
            len_err_d = 1'b1;
            wr_ptr_d  = '0;
          end else begin
            wr_ptr_d = ADDR_W'(1);
            state_d  = LDR_LOAD;
          end
        end
      end
      LDR_LOAD: begin
        if (beat_c) begin
          we_c = 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            if (s_last) begin
              state_d = LDR_COMMIT;
            end else begin
              len_err_d = 1'b1;
              state_d   = LDR_DRAIN;
            end
          end else if (s_last) begin
            len_err_d = 1'b1;
            wr_ptr_d  = '0;
            state_d   = LDR_IDLE;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      // Overlong frame: swallow the tail silently until its last beat.
      LDR_DRAIN: begin
        if (beat_c && s_last) begin
          state_d = LDR_IDLE;
        end
      end
      LDR_COMMIT: begin
        bank_sel_d   = ~bank_sel_q;
        commit_d     = 1'b1;
        coef_valid_d = 1'b1;
        wr_ptr_d     = '0;
        state_d      = LDR_IDLE;
      end
      default: state_d = LDR_IDLE;
    endcase

    s_ready_d = (state_d != LDR_COMMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LDR_IDLE;
      wr_ptr_q     <= '0;
      s_ready_q    <= 1'b0;
      bank_sel_q   <= 1'b0;
      coef_valid_q <= 1'b0;
      commit_q     <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      s_ready_q    <= s_ready_d;
      bank_sel_q   <= bank_sel_d;
      coef_valid_q <= coef_valid_d;
      commit_q     <= commit_d;
      len_err_q    <= len_err_d;
    end
  end

  // Writes target the shadow bank; the filter reads the active one.
  fir_coef_bank #(
    .NUM_TAPS (NUM_TAPS),
    .COEF_W   (COEF_W),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_bank (~bank_sel_q),
    .wr_addr (wr_addr_c),
    .wr_data (s_data),
    .we      (we_c),
    .rd_bank (bank_sel_q),
    .rd_addr (rd_addr),
    .rd_data (rd_coef)
  );

  assign s_ready    = s_ready_q;
  assign bank_sel   = bank_sel_q;
  assign coef_valid = coef_valid_q;
  assign commit     = commit_q;
  assign len_err    = len_err_q;

endmodule
